tdm_demux4: RTL and testbench

//  Receive end of the 4:1 mux path: takes one time-division-multiplexed sample

---
 rtl/tdm_demux4.sv | 111 +++++++++++
 tb/tb_tdm_demux4.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// Receive side of a 4-slot TDM link: rebuilds four parallel channels from one
// sample stream, publishing a whole frame at once and flagging framing slips.
module tdm_demux4 #(
   parameter int DATA_W = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              frame_start,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] y0,
   output logic [DATA_W-1:0] y1,
   output logic [DATA_W-1:0] y2,
   output logic [DATA_W-1:0] y3,
   output logic              frame_valid,
   output logic [1:0]        sel,
   output logic              sync_err
);

   // Handshake: valid-only, no backpressure. A sample (din, frame_start) is
   // consumed on every rising edge where in_valid=1; in_valid=0 freezes all state.

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [DATA_W-1:0] shadow_q [3];
   logic [DATA_W-1:0] shadow_d [3];
   logic [DATA_W-1:0] y0_d, y1_d, y2_d, y3_d;
   logic              fv_d, se_d;

   assign sel = sel_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= 2'd0;
         shadow_q[0] <= '0;
         shadow_q[1] <= '0;
         shadow_q[2] <= '0;
         y0          <= '0;
         y1          <= '0;
         y2          <= '0;
         y3          <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         shadow_q    <= shadow_d;
         y0          <= y0_d;
         y1          <= y1_d;
         y2          <= y2_d;
         y3          <= y3_d;
         frame_valid <= fv_d;
         sync_err    <= se_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      y0_d     = y0;
      y1_d     = y1;
      y2_d     = y2;
      y3_d     = y3;
      fv_d     = 1'b0;
      se_d     = 1'b0;
      if (in_valid) begin
         unique case (state_q)
            IDLE: begin
               if (frame_start) begin
                  shadow_d[0] = din;
                  sel_d       = 2'd1;
                  state_d     = RUN;
               end
            end
            RUN: begin
               if (sel_q == 2'd0) begin
                  if (frame_start) begin
                     shadow_d[0] = din;
                     sel_d       = 2'd1;
                  end else begin
                     se_d    = 1'b1;
                     state_d = IDLE;
                  end
               end else if (frame_start) begin
                  // Early frame: abandon the partial frame, this sample is the new slot 0.
                  se_d        = 1'b1;
                  shadow_d[0] = din;
                  sel_d       = 2'd1;
               end else if (sel_q == 2'd3) begin
                  y0_d  = shadow_q[0];
                  y1_d  = shadow_q[1];
                  y2_d  = shadow_q[2];
                  y3_d  = din;
                  fv_d  = 1'b1;
                  sel_d = 2'd0;
               end else begin
                  if (sel_q == 2'd1) shadow_d[1] = din;
                  else               shadow_d[2] = din;
                  sel_d = sel_q + 2'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a 1-bit instance for framing behaviour and an
// 8-bit instance for a back-to-back stream.
module tb_tdm_demux4;

   logic       clk;
   logic       rst, in_valid, frame_start;
   logic [0:0] din, y0, y1, y2, y3;
   logic       frame_valid, sync_err;
   logic [1:0] sel;

   logic       rst8, v8, fs8;
   logic [7:0] din8, y08, y18, y28, y38;
   logic       fv8, se8;
   logic [1:0] sel8;

   int checks = 0;
   int errors = 0;

   tdm_demux4 #(.DATA_W(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start), .din(din),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3),
      .frame_valid(frame_valid), .sel(sel), .sync_err(sync_err)
   );

   tdm_demux4 #(.DATA_W(8)) dut8 (
      .clk(clk), .rst(rst8), .in_valid(v8), .frame_start(fs8), .din(din8),
      .y0(y08), .y1(y18), .y2(y28), .y3(y38),
      .frame_valid(fv8), .sel(sel8), .sync_err(se8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of inputs, then sample #1 after the rising edge.
   task automatic step(input logic v, input logic fs, input logic d);
      in_valid    = v;
      frame_start = fs;
      din         = d;
      @(posedge clk);
      #1;
   endtask

   task automatic step8(input logic v, input logic fs, input logic [7:0] d);
      v8   = v;
      fs8  = fs;
      din8 = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 0);
      step(0, 0, 0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({y0, y1, y2, y3} !== 4'b0000 || sel !== 2'd0 || frame_valid !== 1'b0 || sync_err !== 1'b0) begin
         errors++;
         $display("FAIL reset: y=%b sel=%0d fv=%b se=%b, want y=0000 sel=0 fv=0 se=0",
                  {y0, y1, y2, y3}, sel, frame_valid, sync_err);
      end
   endtask

   task automatic test_basic_frame();
      logic [3:0] d;
      d = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         step(1, i == 0, d[3-i]);
         checks++;
         if (frame_valid !== (i == 3) || sel !== 2'((i + 1) % 4)) begin
            errors++;
            $display("FAIL basic_slot%0d: fv=%b sel=%0d, want fv=%b sel=%0d",
                     i, frame_valid, sel, i == 3, (i + 1) % 4);
         end
      end
      checks++;
      if ({y0, y1, y2, y3} !== 4'b1011) begin
         errors++;
         $display("FAIL basic_y: got %b want 1011", {y0, y1, y2, y3});
      end
      step(0, 0, 0);
      checks++;
      if (frame_valid !== 1'b0 || {y0, y1, y2, y3} !== 4'b1011) begin
         errors++;
         $display("FAIL basic_after: fv=%b y=%b, want fv=0 y=1011", frame_valid, {y0, y1, y2, y3});
      end
   endtask

   task automatic test_gaps();
      logic [3:0] d;
      int fv_cnt;
      d = 4'b1011;
      fv_cnt = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1, i == 0, d[3-i]);
         fv_cnt += int'(frame_valid);
         for (int g = 0; g < 3; g++) begin
            // frame_start high during a gap must be ignored
            step(0, g == 1, 1'b0);
            fv_cnt += int'(frame_valid);
         end
         checks++;
         if (sel !== 2'((i + 1) % 4) || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL gaps_sel%0d: sel=%0d se=%b, want sel=%0d se=0", i, sel, sync_err, (i + 1) % 4);
         end
      end
      checks++;
      if ({y0, y1, y2, y3} !== 4'b1011 || fv_cnt !== 1) begin
         errors++;
         $display("FAIL gaps_result: y=%b fv_pulses=%0d, want y=1011 fv_pulses=1", {y0, y1, y2, y3}, fv_cnt);
      end
   endtask

   task automatic test_early_frame();
      for (int i = 0; i < 4; i++) step(1, i == 0, 1'b1);
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 1, 0);   // frame_start on the 3rd sample
      checks++;
      if (sync_err !== 1'b1 || frame_valid !== 1'b0 || sel !== 2'd1 || {y0, y1, y2, y3} !== 4'b1111) begin
         errors++;
         $display("FAIL early_err: se=%b fv=%b sel=%0d y=%b, want se=1 fv=0 sel=1 y=1111",
                  sync_err, frame_valid, sel, {y0, y1, y2, y3});
      end
      step(1, 0, 1);
      checks++;
      if (sync_err !== 1'b0) begin
         errors++;
         $display("FAIL early_pulse: se=%b want 0", sync_err);
      end
      step(1, 0, 0);
      step(1, 0, 1);
      checks++;
      if (frame_valid !== 1'b1 || {y0, y1, y2, y3} !== 4'b0101) begin
         errors++;
         $display("FAIL early_resync: fv=%b y=%b, want fv=1 y=0101", frame_valid, {y0, y1, y2, y3});
      end
   endtask

   task automatic test_lost_sync();
      step(1, 0, 1);   // slot 0 without frame_start
      checks++;
      if (sync_err !== 1'b1 || sel !== 2'd0 || frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL lost_err: se=%b sel=%0d fv=%b, want se=1 sel=0 fv=0", sync_err, sel, frame_valid);
      end
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 1);
         checks++;
         if (sync_err !== 1'b0 || frame_valid !== 1'b0 || sel !== 2'd0) begin
            errors++;
            $display("FAIL lost_idle%0d: se=%b fv=%b sel=%0d, want 0 0 0", i, sync_err, frame_valid, sel);
         end
      end
      step(1, 1, 0);
      step(1, 0, 0);
      step(1, 0, 1);
      step(1, 0, 1);
      checks++;
      if (frame_valid !== 1'b1 || {y0, y1, y2, y3} !== 4'b0011) begin
         errors++;
         $display("FAIL lost_recover: fv=%b y=%b, want fv=1 y=0011", frame_valid, {y0, y1, y2, y3});
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] d;
      int fv_cnt;
      d = 4'b0101;
      fv_cnt = 0;
      step(1, 1, 1);
      step(1, 0, 1);
      do_reset();
      checks++;
      if ({y0, y1, y2, y3} !== 4'b0000 || sel !== 2'd0) begin
         errors++;
         $display("FAIL midrst_state: y=%b sel=%0d, want y=0000 sel=0", {y0, y1, y2, y3}, sel);
      end
      // Slots without frame_start must not resume the aborted frame.
      step(1, 0, 1);
      step(1, 0, 1);
      fv_cnt += int'(frame_valid);
      for (int i = 0; i < 4; i++) begin
         step(1, i == 0, d[3-i]);
         fv_cnt += int'(frame_valid);
      end
      checks++;
      if ({y0, y1, y2, y3} !== 4'b0101) begin
         errors++;
         $display("FAIL midrst_y: got %b want 0101", {y0, y1, y2, y3});
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0);
         fv_cnt += int'(frame_valid);
      end
      checks++;
      if (fv_cnt !== 1) begin
         errors++;
         $display("FAIL midrst_fv: pulses=%0d want 1", fv_cnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e0, e1, e2, e3;
      rst8 = 1'b1;
      step8(0, 0, 8'h00);
      step8(0, 0, 8'h00);
      rst8 = 1'b0;
      for (int f = 0; f < 3; f++) begin
         for (int s = 0; s < 4; s++) begin
            step8(1, s == 0, 8'(8'hA0 + 16 * f + 3 * s));
            checks++;
            if (fv8 !== (s == 3) || se8 !== 1'b0) begin
               errors++;
               $display("FAIL b2b_fv f%0d s%0d: fv=%b se=%b, want fv=%b se=0", f, s, fv8, se8, s == 3);
            end
         end
         e0 = 8'(8'hA0 + 16 * f);
         e1 = 8'(8'hA0 + 16 * f + 3);
         e2 = 8'(8'hA0 + 16 * f + 6);
         e3 = 8'(8'hA0 + 16 * f + 9);
         checks++;
         if (y08 !== e0 || y18 !== e1 || y28 !== e2 || y38 !== e3) begin
            errors++;
            $display("FAIL b2b_y f%0d: got %h %h %h %h want %h %h %h %h",
                     f, y08, y18, y28, y38, e0, e1, e2, e3);
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; din = '0;
      rst8 = 1'b1; v8 = 1'b0; fs8 = 1'b0; din8 = '0;
      test_reset();
      test_basic_frame();
      test_gaps();
      test_early_frame();
      test_lost_sync();
      test_mid_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
